ws2812_frame_serializer: RTL and testbench
==========================================

Name: ws2812_frame_serializer

Overview:
- Upstream stage of prescaler_selector; converts a frame of NUM_LEDS GRB pixels into a bit stream for the LED stripe.
- Accepts pixels over a valid/ready handshake.
- Presents one bit at a time on bit_to_transmit and advances on new_bit_rqst.
- After the last bit, flags all_bits_shifted, times the stripe latch (reset) period, then pulses reset_finish.

Parameters:
- NUM_LEDS, 8: pixels per frame.
- BITS_PER_LED, 24: bits per pixel, GRB order, MSB first.
- RESET_CYCLES, 1250: latch low time in clk cycles (50 us at 25 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pix_data  in  BITS_PER_LED  pixel {G,R,B}
- pix_valid  in  1  pix_data valid
- pix_ready  out  1  holding register free; transfer when pix_valid & pix_ready
- new_bit_rqst  in  1  single-cycle pulse from prescaler_selector: current bit consumed, advance
- bit_to_transmit  out  1  current bit, registered
- all_bits_shifted  out  1  level: frame fully shifted, latch period in progress
- reset_finish  out  1  single-cycle pulse: latch period elapsed
- busy  out  1  frame in progress (SHIFT or LATCH)
- underflow  out  1  sticky: next pixel missing mid-frame; cleared only by rst

Behaviour:
- Reset (synchronous, rst=1 at clk edge): state IDLE, all counters 0, holding register empty.
  - Outputs: pix_ready=1, bit_to_transmit=0, all_bits_shifted=0, reset_finish=0, busy=0, underflow=0.
  - Asserting rst mid-frame or mid-latch aborts immediately; no reset_finish pulse is issued.
- Datapath: shift register sh[BITS_PER_LED-1:0], one-entry holding register hold/hold_full.
  - Counters: bit_cnt (0..BITS_PER_LED-1), pix_cnt (0..NUM_LEDS-1), lat_cnt (0..RESET_CYCLES-1).
  - bit_to_transmit is sh MSB.
- pix_ready = !hold_full, in every state except LATCH (0 in LATCH).
- IDLE:
  - A pixel transfer writes hold.
  - When hold_full, the next cycle loads sh from hold, clears hold_full, sets bit_cnt=0, pix_cnt=0 and goes to SHIFT.
  - First bit is valid 2 cycles after the transfer cycle.
- SHIFT, on new_bit_rqst:
  - bit_cnt < BITS_PER_LED-1: shift sh left by 1, bit_cnt++.
  - Last bit and pix_cnt < NUM_LEDS-1 and hold_full (or hold being written this cycle): load sh from hold, bit_cnt=0, pix_cnt++. No gap cycle.
  - Last bit, pix_cnt < NUM_LEDS-1, hold empty: set underflow; go to LATCH (frame truncated).
  - Last bit, pix_cnt == NUM_LEDS-1: go to LATCH.
- SHIFT without new_bit_rqst: hold all state; bit_to_transmit stable.
- LATCH:
  - all_bits_shifted=1, bit_to_transmit=0, lat_cnt counts up every cycle.
  - At lat_cnt == RESET_CYCLES-1: reset_finish=1 for one cycle, all_bits_shifted drops the same edge, go to IDLE.
- new_bit_rqst in IDLE or LATCH is ignored.
- A pixel arriving in the same cycle as the last-bit request is accepted and used. Write has priority into the empty hold; the bypass loads sh directly.
- busy = state != IDLE.
- Width rules: all counters sized with $clog2 of their range (minimum 1 bit); no wrap beyond their terminal value.

Optional Feature:
- Macro: WS2812_UNDERFLOW_BLACK_EN.
- Defined: on underflow, set underflow, load sh with all zeros and continue SHIFT. The frame always completes NUM_LEDS pixels (missing pixels sent black).
  - Pixels arriving later fill the remaining slots normally.
- Undefined: truncate to LATCH as above.

Decomposition:
- Shared package ws2812_pkg:
  - BITS_PER_LED and RESET_CYCLES defaults.
  - pixel_t typedef (24-bit GRB).
  - State enum {IDLE, SHIFT, LATCH}.
- One natural sub-module: ws2812_latch_timer (lat_cnt, start/done pulse). It is reusable by prescaler_selector-side timing.

Test Plan (NUM_LEDS=2, RESET_CYCLES=10):
- Reset: rst=1 for 2 cycles -> all outputs at reset values, pix_ready=1.
- Single frame: send 0xA50000 then 0x0000FF, pulse new_bit_rqst every 4 cycles.
  - Bit sequence is 1,0,1,0,0,1,0,1 followed by 16 zeros, then 16 zeros followed by 8 ones.
  - all_bits_shifted=1 after 48th request; reset_finish pulses exactly 10 cycles later.
- Back-to-back: second pixel presented simultaneously with the 24th request -> no gap; 25th bit is pixel 2 MSB; pix_ready stays consistent.
- Underflow: send 1 pixel only, issue 24 requests.
  - underflow=1, LATCH entered, reset_finish after 10 cycles.
  - With WS2812_UNDERFLOW_BLACK_EN: 24 further zero bits first.
- Reset mid-operation: rst asserted after 10 bits, and again at lat_cnt=5 -> IDLE next cycle, no reset_finish, hold empty.
- Stall: no new_bit_rqst for 100 cycles in SHIFT -> bit_to_transmit and counters unchanged; stray new_bit_rqst in IDLE/LATCH has no effect.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared types and defaults for the WS2812 frame serializer and its latch timer.
package ws2812_pkg;

  localparam int BITS_PER_LED = 24;
  localparam int RESET_CYCLES = 1250;

  typedef logic [BITS_PER_LED-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_t;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ws2812_frame_serializer_if.sv
// Pixel handshake and bit-stream signals between the serializer and its neighbours.
interface ws2812_frame_serializer_if #(
  parameter int BITS_PER_LED = ws2812_pkg::BITS_PER_LED
);
  import ws2812_pkg::*;

  logic [BITS_PER_LED-1:0] pix_data;
  logic                    pix_valid;
  logic                    pix_ready;
  logic                    new_bit_rqst;
  logic                    bit_to_transmit;
  logic                    all_bits_shifted;
  logic                    reset_finish;
  logic                    busy;
  logic                    underflow;

  modport master (
    output pix_data, pix_valid, new_bit_rqst,
    input  pix_ready, bit_to_transmit, all_bits_shifted, reset_finish, busy, underflow
  );

  modport slave (
    input  pix_data, pix_valid, new_bit_rqst,
    output pix_ready, bit_to_transmit, all_bits_shifted, reset_finish, busy, underflow
  );

endinterface

// File: rtl/ws2812_latch_timer.sv
// Counts CYCLES clocks while i_run is high; o_last marks the final cycle, o_done pulses one cycle later.
module ws2812_latch_timer #(
  parameter int CYCLES = ws2812_pkg::RESET_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  output logic o_last,
  output logic o_done
);
  import ws2812_pkg::*;

  localparam int            CW     = cnt_width(CYCLES);
  localparam logic [CW-1:0] C_LAST = CW'(CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_done;

  assign o_last = i_run && (r_cnt == C_LAST);
  assign o_done = r_done;

  // Counter idles at zero so every run starts from a clean count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= o_last;
      if (!i_run || o_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ws2812_frame_serializer.sv
// Serializes a frame of GRB pixels MSB first, then times the stripe latch period.
// Build option WS2812_UNDERFLOW_BLACK_EN: a missing pixel is sent black instead of truncating the frame.
module ws2812_frame_serializer #(
  parameter int NUM_LEDS     = 8,
  parameter int BITS_PER_LED = ws2812_pkg::BITS_PER_LED,
  parameter int RESET_CYCLES = ws2812_pkg::RESET_CYCLES
) (
  input logic                      clk,
  input logic                      rst,
  ws2812_frame_serializer_if.slave bus
);
  import ws2812_pkg::*;

  localparam int            BW       = cnt_width(BITS_PER_LED);
  localparam int            PW       = cnt_width(NUM_LEDS);
  localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_LED - 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(NUM_LEDS - 1);

  state_t                  r_state;
  logic [BITS_PER_LED-1:0] r_sh;
  logic [BITS_PER_LED-1:0] r_hold;
  logic                    r_hold_full;
  logic [BW-1:0]           r_bit_cnt;
  logic [PW-1:0]           r_pix_cnt;
  logic                    r_underflow;
  logic                    r_all_shifted;

  logic w_pix_ready;
  logic w_xfer;
  logic w_last_bit;
  logic w_more_pix;
  logic w_bypass;
  logic w_latching;
  logic w_lat_last;
  logic w_lat_done;

  assign w_pix_ready = !r_hold_full && (r_state != LATCH);
  assign w_xfer      = bus.pix_valid && w_pix_ready;
  assign w_last_bit  = (r_bit_cnt == BIT_LAST);
  assign w_more_pix  = (r_pix_cnt != PIX_LAST);
  assign w_latching  = (r_state == LATCH);
  // A pixel landing with the last-bit request goes straight into the shifter.
  assign w_bypass    = (r_state == SHIFT) && bus.new_bit_rqst && w_last_bit && w_more_pix && w_xfer;

  ws2812_latch_timer #(
    .CYCLES (RESET_CYCLES)
  ) u_latch_timer (
    .clk    (clk),
    .rst    (rst),
    .i_run  (w_latching),
    .o_last (w_lat_last),
    .o_done (w_lat_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_sh          <= '0;
      r_hold        <= '0;
      r_hold_full   <= 1'b0;
      r_bit_cnt     <= '0;
      r_pix_cnt     <= '0;
      r_underflow   <= 1'b0;
      r_all_shifted <= 1'b0;
    end else begin
      if (w_xfer && !w_bypass) begin
        r_hold      <= bus.pix_data;
        r_hold_full <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (r_hold_full) begin
            r_sh        <= r_hold;
            r_hold_full <= 1'b0;
            r_bit_cnt   <= '0;
            r_pix_cnt   <= '0;
            r_state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.new_bit_rqst) begin
            if (!w_last_bit) begin
              r_sh      <= r_sh << 1;
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end else if (w_more_pix && r_hold_full) begin
              r_sh        <= r_hold;
              r_hold_full <= 1'b0;
              r_bit_cnt   <= '0;
              r_pix_cnt   <= r_pix_cnt + PW'(1);
            end else if (w_bypass) begin
              r_sh      <= bus.pix_data;
              r_bit_cnt <= '0;
              r_pix_cnt <= r_pix_cnt + PW'(1);
            end else if (w_more_pix) begin
              r_underflow <= 1'b1;
              r_sh        <= '0;
`ifdef WS2812_UNDERFLOW_BLACK_EN
              r_bit_cnt   <= '0;
              r_pix_cnt   <= r_pix_cnt + PW'(1);
`else
              r_state       <= LATCH;
              r_all_shifted <= 1'b1;
`endif
            end else begin
              // Clearing the shifter keeps the line low for the whole latch period.
              r_sh          <= '0;
              r_state       <= LATCH;
              r_all_shifted <= 1'b1;
            end
          end
        end
        LATCH: begin
          if (w_lat_last) begin
            r_state       <= IDLE;
            r_all_shifted <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.pix_ready        = w_pix_ready;
  assign bus.bit_to_transmit  = r_sh[BITS_PER_LED-1];
  assign bus.all_bits_shifted = r_all_shifted;
  assign bus.reset_finish     = w_lat_done;
  assign bus.busy             = (r_state != IDLE);
  assign bus.underflow        = r_underflow;

endmodule

// File: tb/tb_ws2812_frame_serializer.sv
// Directed bench for ws2812_frame_serializer with NUM_LEDS=2, RESET_CYCLES=10.
module tb_ws2812_frame_serializer;
  import ws2812_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ws2812_frame_serializer_if #(.BITS_PER_LED(24)) bus ();

  ws2812_frame_serializer #(
    .NUM_LEDS     (2),
    .BITS_PER_LED (24),
    .RESET_CYCLES (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pixel(input logic [23:0] d);
    int n;
    n = 0;
    bus.pix_data  = d;
    bus.pix_valid = 1'b1;
    while (!bus.pix_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_ready", 64'(bus.pix_ready), 64'(1));
    tick();
    bus.pix_valid = 1'b0;
  endtask

  task automatic req(output logic b);
    b = bus.bit_to_transmit;
    bus.new_bit_rqst = 1'b1;
    tick();
    bus.new_bit_rqst = 1'b0;
  endtask

  task automatic shift_bits(input int count, input int gap, output logic [47:0] s);
    logic b;
    s = '0;
    for (int i = 0; i < count; i++) begin
      repeat (gap) tick();
      req(b);
      s = {s[46:0], b};
    end
  endtask

  task automatic wait_rf(input bit stray, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      bus.new_bit_rqst = stray & i[0];
      tick();
      if (bus.reset_finish) begin
        n = i;
        break;
      end
    end
    bus.new_bit_rqst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [47:0] s, s1, s2, s3;
    logic [23:0] p1, p2;
    logic        b, v;
    int          n, pulses;

    rst = 1'b1;
    bus.pix_data = '0;
    bus.pix_valid = 1'b0;
    bus.new_bit_rqst = 1'b0;
    tick();
    tick();
    check("rst_ready", 64'(bus.pix_ready), 64'(1));
    check("rst_bit", 64'(bus.bit_to_transmit), 64'(0));
    check("rst_all", 64'(bus.all_bits_shifted), 64'(0));
    check("rst_rf", 64'(bus.reset_finish), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_uf", 64'(bus.underflow), 64'(0));
    rst = 1'b0;

    // Single frame, with stray requests in IDLE first.
    repeat (3) req(b);
    check("idle_stray_busy", 64'(bus.busy), 64'(0));
    p1 = 24'hA50000;
    p2 = 24'h0000FF;
    send_pixel(p1);
    check("sf_busy_after_xfer", 64'(bus.busy), 64'(0));
    tick();
    check("sf_busy_first", 64'(bus.busy), 64'(1));
    check("sf_first_bit", 64'(bus.bit_to_transmit), 64'(1));
    send_pixel(p2);
    shift_bits(48, 3, s);
    check("sf_stream", 64'(s), 64'({p1, p2}));
    check("sf_all_set", 64'(bus.all_bits_shifted), 64'(1));
    check("sf_latch_bit", 64'(bus.bit_to_transmit), 64'(0));
    check("sf_latch_ready", 64'(bus.pix_ready), 64'(0));
    wait_rf(1'b1, n);
    check("sf_rf_delay", 64'(n), 64'(10));
    check("sf_all_clr", 64'(bus.all_bits_shifted), 64'(0));
    check("sf_busy_end", 64'(bus.busy), 64'(0));
    tick();
    check("sf_rf_single", 64'(bus.reset_finish), 64'(0));

    // Back-to-back bypass on the 24th request, with a stall after 10 bits.
    p1 = 24'h123456;
    p2 = 24'hC3C3C3;
    send_pixel(p1);
    shift_bits(10, 3, s1);
    v = p1[13];
    repeat (100) tick();
    check("stall_bit", 64'(bus.bit_to_transmit), 64'(v));
    check("stall_busy", 64'(bus.busy), 64'(1));
    shift_bits(13, 3, s2);
    repeat (3) tick();
    check("b2b_ready_last", 64'(bus.pix_ready), 64'(1));
    bus.pix_data = p2;
    bus.pix_valid = 1'b1;
    req(b);
    bus.pix_valid = 1'b0;
    check("b2b_bit25", 64'(bus.bit_to_transmit), 64'(1));
    check("b2b_ready_after", 64'(bus.pix_ready), 64'(1));
    shift_bits(24, 3, s3);
    s = {s1[9:0], s2[12:0], b, s3[23:0]};
    check("b2b_stream", 64'(s), 64'({p1, p2}));
    check("b2b_uf", 64'(bus.underflow), 64'(0));
    check("b2b_all", 64'(bus.all_bits_shifted), 64'(1));
    wait_rf(1'b0, n);
    check("b2b_rf_delay", 64'(n), 64'(10));

    // Underflow: only one pixel for a two-pixel frame.
    p1 = 24'hFF00FF;
    send_pixel(p1);
    shift_bits(24, 3, s);
    check("uf_stream", 64'(s[23:0]), 64'(p1));
    check("uf_flag", 64'(bus.underflow), 64'(1));
`ifdef WS2812_UNDERFLOW_BLACK_EN
    check("uf_black_all", 64'(bus.all_bits_shifted), 64'(0));
    shift_bits(24, 1, s);
    check("uf_black_stream", 64'(s[23:0]), 64'(0));
`endif
    check("uf_all", 64'(bus.all_bits_shifted), 64'(1));
    wait_rf(1'b0, n);
    check("uf_rf_delay", 64'(n), 64'(10));
    check("uf_sticky", 64'(bus.underflow), 64'(1));

    // Reset after 10 bits with a pixel waiting in hold.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_uf_clr", 64'(bus.underflow), 64'(0));
    send_pixel(24'hFFFFFF);
    send_pixel(24'hFFFFFF);
    shift_bits(10, 0, s);
    check("mid_stream", 64'(s[9:0]), 64'(10'h3FF));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_busy", 64'(bus.busy), 64'(0));
    check("mid_ready", 64'(bus.pix_ready), 64'(1));
    check("mid_bit", 64'(bus.bit_to_transmit), 64'(0));
    repeat (5) tick();
    check("mid_hold_empty", 64'(bus.busy), 64'(0));

    // Reset at lat_cnt=5 must suppress reset_finish.
    send_pixel(24'h00FF00);
    send_pixel(24'h0000FF);
    shift_bits(48, 0, s);
    check("lat_all", 64'(bus.all_bits_shifted), 64'(1));
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("lat_rst_busy", 64'(bus.busy), 64'(0));
    check("lat_rst_all", 64'(bus.all_bits_shifted), 64'(0));
    check("lat_rst_ready", 64'(bus.pix_ready), 64'(1));
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.reset_finish) pulses++;
      tick();
    end
    check("lat_rst_no_rf", 64'(pulses), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
